operand_loader: RTL and testbench

Upstream front end for `eight_bit_comparator`. It debounces the four pushbuttons PB1–PB4 and uses them to load the 4-bit switch value Y into the nibbles of two 8-bit operands, A and B. Once all four nibbles have been loaded, it presents A and B to the comparator over a valid/ready handshake. The comparator then consumes a stable operand pair instead of raw, bouncing button levels.

---
 rtl/operand_loader_pkg.sv | 18 +
 rtl/pb_debounce.sv | 59 +++++
 rtl/operand_loader.sv | 100 ++++++++++
 tb/tb_operand_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader front end.
`timescale 1ns/1ps
package operand_loader_pkg;

    typedef enum logic {
        COLLECT,
        PRESENT
    } ldr_state_t;

    // Nibble slots, indexed by button: PB1..PB4 -> 0..3
    localparam int unsigned NIB_A_LO = 0;
    localparam int unsigned NIB_A_HI = 1;
    localparam int unsigned NIB_B_LO = 2;
    localparam int unsigned NIB_B_HI = 3;

    localparam logic [3:0] LOADED_ALL = 4'b1111;

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton synchronizer + debouncer; press_o pulses on the edge where the
// debounced level rises.
`timescale 1ns/1ps
module pb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer for the raw button level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pb_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce counter: a level change is accepted after DEBOUNCE_CYCLES differing cycles
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Debounced level and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // Event is combinational so the nibble loads on the same edge db rises
    assign press_o = db_d & ~db_q;

endmodule

// File: rtl/operand_loader.sv
// Loads the switch nibble Y into operands A/B on debounced button presses and
// presents the completed pair over a valid/ready handshake.
`timescale 1ns/1ps
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Y,
    input  logic       PB1,
    input  logic       PB2,
    input  logic       PB3,
    input  logic       PB4,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] loaded
);

    logic [3:0]      pb_raw;
    logic [3:0]      press;
    logic [3:0]      y_s1_q, y_s2_q;
    logic [3:0][3:0] nib_q, nib_d;
    logic [3:0]      loaded_q, loaded_d;
    ldr_state_t      state_q, state_d;

    assign pb_raw = {PB4, PB3, PB2, PB1};

    for (genvar g = 0; g < 4; g++) begin : gen_db
        pb_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_pb_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .pb_i   (pb_raw[g]),
            .press_o(press[g])
        );
    end

    // Two-flop synchronizer for the switch nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s1_q <= '0;
            y_s2_q <= '0;
        end else begin
            y_s1_q <= Y;
            y_s2_q <= y_s1_q;
        end
    end

    // Next-state: load nibbles while collecting, hand off when all four are in
    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        nib_d    = nib_q;
        unique case (state_q)
            COLLECT: begin
                for (int i = 0; i < 4; i++) begin
                    if (press[i]) begin
                        nib_d[i]    = y_s2_q;
                        loaded_d[i] = 1'b1;
                    end
                end
                if (loaded_d == LOADED_ALL) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Operands stay put after acceptance so the result remains visible
                if (out_ready) begin
                    loaded_d = '0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State, nibble and loaded-mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            loaded_q <= '0;
            nib_q    <= '0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            nib_q    <= nib_d;
        end
    end

    assign a         = {nib_q[NIB_A_HI], nib_q[NIB_A_LO]};
    assign b         = {nib_q[NIB_B_HI], nib_q[NIB_B_LO]};
    assign loaded    = loaded_q;
    assign out_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader (DEBOUNCE_CYCLES = 16).
`timescale 1ns/1ps
module tb_operand_loader;

    localparam int unsigned DB = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] Y;
    logic       PB1, PB2, PB3, PB4;
    logic [7:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] loaded;

    int tests;
    int fails;
    int valid_cycles;
    bit count_en;

    operand_loader #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Y        (Y),
        .PB1      (PB1),
        .PB2      (PB2),
        .PB3      (PB3),
        .PB4      (PB4),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .loaded   (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with out_valid high while enabled
    always @(negedge clk) begin
        if (count_en && out_valid) valid_cycles <= valid_cycles + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pb(input logic [3:0] m);
        {PB4, PB3, PB2, PB1} = m;
    endtask

    // Full debounced press and release of the buttons in mask with switch value y
    task automatic press(input logic [3:0] mask, input logic [3:0] y);
        Y = y;
        tick(3);
        set_pb(mask);
        tick(DB + 4);
        set_pb(4'b0000);
        tick(DB + 4);
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (a !== 8'h00) begin fails++; $display("FAIL reset_a: got %h want 00", a); end
        tests++; if (b !== 8'h00) begin fails++; $display("FAIL reset_b: got %h want 00", b); end
        tests++; if (loaded !== 4'h0) begin fails++; $display("FAIL reset_loaded: got %b want 0000", loaded); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_full_load();
        press(4'b0001, 4'h5);
        press(4'b0010, 4'h0);
        press(4'b0100, 4'hE);
        tests++; if (loaded !== 4'b0111) begin fails++; $display("FAIL full_loaded3: got %b want 0111", loaded); end
        // PB4 timed by hand: load edge is DB+2 edges after PB set on a negedge
        Y = 4'hF;
        tick(3);
        set_pb(4'b1000);
        tick(DB + 1);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_valid_early: got %b want 0", out_valid); end
        tick(1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_valid_rise: got %b want 1", out_valid); end
        tests++; if (loaded !== 4'b1111) begin fails++; $display("FAIL full_loaded4: got %b want 1111", loaded); end
        tests++; if (a !== 8'h05) begin fails++; $display("FAIL full_a: got %h want 05", a); end
        tests++; if (b !== 8'hFE) begin fails++; $display("FAIL full_b: got %h want fe", b); end
        set_pb(4'b0000);
        tick(DB + 4);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_valid_hold: got %b want 1", out_valid); end
        pulse_ready();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL accept_valid: got %b want 0", out_valid); end
        tests++; if (loaded !== 4'b0000) begin fails++; $display("FAIL accept_loaded: got %b want 0000", loaded); end
        tests++; if (a !== 8'h05 || b !== 8'hFE) begin
            fails++; $display("FAIL accept_retain: got a=%h b=%h want a=05 b=fe", a, b);
        end
    endtask

    task automatic test_bounce();
        Y = 4'h6;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            PB1 = (i % 2 == 0);
            tick(3);
        end
        PB1 = 1'b1;
        tick(DB + 1);
        tests++; if (loaded !== 4'b0000) begin fails++; $display("FAIL bounce_early: got %b want 0000", loaded); end
        tick(1);
        tests++; if (loaded !== 4'b0001) begin fails++; $display("FAIL bounce_load: got %b want 0001", loaded); end
        tests++; if (a[3:0] !== 4'h6) begin fails++; $display("FAIL bounce_nib: got %h want 6", a[3:0]); end
        // A held button must not produce a second event
        Y = 4'h1;
        tick(3 * DB);
        tests++; if (a[3:0] !== 4'h6) begin fails++; $display("FAIL hold_single: got %h want 6", a[3:0]); end
        PB1 = 1'b0;
        tick(DB + 4);
    endtask

    task automatic test_overwrite();
        press(4'b0001, 4'h3);
        press(4'b0001, 4'h9);
        tests++; if (loaded !== 4'b0001) begin fails++; $display("FAIL overwrite_loaded: got %b want 0001", loaded); end
        tests++; if (a[3:0] !== 4'h9) begin fails++; $display("FAIL overwrite_nib: got %h want 9", a[3:0]); end
        press(4'b1110, 4'hA);
        tests++; if (a !== 8'hA9) begin fails++; $display("FAIL simul_a: got %h want a9", a); end
        tests++; if (b !== 8'hAA) begin fails++; $display("FAIL simul_b: got %h want aa", b); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL simul_valid: got %b want 1", out_valid); end
    endtask

    task automatic test_present_press();
        press(4'b0001, 4'h7);
        tests++; if (a !== 8'hA9) begin fails++; $display("FAIL present_a: got %h want a9", a); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL present_valid: got %b want 1", out_valid); end
        pulse_ready();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL present_accept: got %b want 0", out_valid); end
        tick(3 * DB);
        tests++; if (loaded !== 4'b0000) begin fails++; $display("FAIL phantom_loaded: got %b want 0000", loaded); end
        tests++; if (a !== 8'hA9) begin fails++; $display("FAIL phantom_a: got %h want a9", a); end
    endtask

    task automatic test_reset_mid();
        press(4'b0001, 4'h1);
        press(4'b0010, 4'h2);
        tests++; if (loaded !== 4'b0011) begin fails++; $display("FAIL mid_loaded2: got %b want 0011", loaded); end
        tests++; if (a !== 8'h21) begin fails++; $display("FAIL mid_a: got %h want 21", a); end
        Y = 4'hC;
        PB3 = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (a !== 8'h00 || b !== 8'h00) begin
            fails++; $display("FAIL async_ab: got a=%h b=%h want 00 00", a, b);
        end
        tests++; if (loaded !== 4'b0000) begin fails++; $display("FAIL async_loaded: got %b want 0000", loaded); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b want 0", out_valid); end
        tick(2);
        rst_n = 1'b1;
        tick(DB + 1);
        tests++; if (loaded !== 4'b0000) begin fails++; $display("FAIL rel_early: got %b want 0000", loaded); end
        tick(1);
        tests++; if (loaded !== 4'b0100) begin fails++; $display("FAIL rel_load: got %b want 0100", loaded); end
        tests++; if (b !== 8'h0C) begin fails++; $display("FAIL rel_b: got %h want 0c", b); end
        PB3 = 1'b0;
        tick(DB + 4);
    endtask

    task automatic test_ready_high();
        out_ready = 1'b1;
        valid_cycles = 0;
        tick(1);
        count_en = 1'b1;
        press(4'b1111, 4'h3);
        tests++; if (valid_cycles !== 1) begin fails++; $display("FAIL rdy_round1: got %0d want 1", valid_cycles); end
        tests++; if (loaded !== 4'b0000) begin fails++; $display("FAIL rdy_loaded1: got %b want 0000", loaded); end
        tests++; if (a !== 8'h33 || b !== 8'h33) begin
            fails++; $display("FAIL rdy_ab1: got a=%h b=%h want 33 33", a, b);
        end
        press(4'b1111, 4'h8);
        tests++; if (valid_cycles !== 2) begin fails++; $display("FAIL rdy_round2: got %0d want 2", valid_cycles); end
        tests++; if (a !== 8'h88 || b !== 8'h88) begin
            fails++; $display("FAIL rdy_ab2: got a=%h b=%h want 88 88", a, b);
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rdy_valid_end: got %b want 0", out_valid); end
        count_en = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        valid_cycles = 0;
        count_en = 1'b0;
        rst_n = 1'b0;
        Y = 4'h0;
        set_pb(4'b0000);
        out_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        test_reset();
        test_full_load();
        test_bounce();
        test_overwrite();
        test_present_press();
        test_reset_mid();
        test_ready_high();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
